video_tim_meas: RTL and testbench
=================================

# video_tim_meas

Receive-side timing analyzer for one video timing dimension (line or frame). It samples a sync/gate pair, such as the output of the team's timing generator or an external source. It measures the sync width, gate delay, gate width and period in the generator's "N means N+1 cycles" encoding, then publishes the four values once per period with a valid strobe and lock/error status. Two instances (horizontal, vertical) sit at the video input path ahead of format detection.

## Interface
- LOCK_LINES, default 2: number of consecutive matching valid periods required to assert locked (1..15).
- clk  in  1  master clock
- rst_n  in  1  reset; asynchronous, active-low
- ena  in  1  sample enable; inputs are sampled and all state advances only on clk edges with ena=1
- sync  in  1  sync pulse, active high
- gate  in  1  gate (active video), active high
- meas_sync  out  8  measured Tsync (high cycles − 1)
- meas_gdel  out  8  measured Tgdel (cycles from sync fall to gate rise − 1)
- meas_gate  out  16  measured Tgate (gate high cycles − 1)
- meas_len  out  16  measured Tlen (sync-rise-to-sync-rise cycles − 1)
- valid  out  1  one-clk pulse; meas_* updated this cycle
- locked  out  1  stable-timing indicator
- err  out  1  one-clk pulse; protocol violation or counter overflow

## Operation
- All cycle counts below are in ena cycles. sync_d/gate_d hold the previous sampled values and are updated on ena cycles only. rise(x) = x & !x_d.
- The state register is one-hot: IDLE, SYNC, GDEL, GATE, LEN.
- IDLE: on rise(sync), go to SYNC. seg_cnt=0, len_cnt=0, ovf=0.
- SYNC: while sync=1, seg_cnt++. When sync=0, cap_sync=seg_cnt, seg_cnt=0, go to GDEL.
- GDEL: while gate=0, seg_cnt++. On rise(gate), cap_gdel=seg_cnt, seg_cnt=0, go to GATE.
- GATE: while gate=1, seg_cnt++. When gate=0, cap_gate=seg_cnt, go to LEN.
- LEN: on rise(sync), close the period (see below) and go to SYNC with seg_cnt=0, len_cnt=0, ovf=0.
- len_cnt increments every ena cycle in SYNC/GDEL/GATE/LEN.
- Period close:
  - If ovf=0: meas_len=len_cnt, and meas_sync/gdel/gate=cap_*. valid=1.
  - If ovf=1: err=1, meas_* hold.
- Saturation:
  - seg_cnt saturates at 255 in SYNC/GDEL and at 65535 in GATE.
  - len_cnt saturates at 65535.
  - Any saturation sets ovf.
  - An 8-bit capture of a seg_cnt value > 255 is impossible because of saturation.
- Protocol errors: err=1, locked=0, match_cnt=0, meas_* hold. The next state is SYNC (counters cleared) if rise(sync) is present in that sample, else IDLE. Errors are:
  - gate=1 sampled in SYNC;
  - sync=1 sampled while in GDEL or GATE, except the simultaneous case below;
  - gate falls and sync rises in the same GATE sample with gate_d=1 is NOT an error: cap_gate is taken, the period closes normally, and the next state is SYNC.
  - sync falling and gate rising in the same sample (from SYNC): error.
- Lock:
  - On each valid, compare the new set against the previously held meas_*. Match → match_cnt++ (saturating at 15); mismatch → match_cnt=0, locked=0.
  - locked=1 when match_cnt ≥ LOCK_LINES.
  - Any err clears locked and match_cnt.
- ena=0: all registers hold, and valid/err go to 0.

## Timing
- Reset values: meas_*=0, valid=0, locked=0, err=0, state=IDLE, sync_d=gate_d=0, all counters and match_cnt=0.
- valid/err/meas_* are registered and change on the same clk edge at which the terminating sample is taken. Zero extra latency beyond the sample edge.
- The first valid occurs at the second observed sync rise. A partial period after reset or IDLE is never reported.
- valid and err are never both 1 in the same cycle.
- A mid-period reset aborts the measurement. Outputs return to reset values asynchronously.

## Test plan
- Generator-shaped stream, ena=1: sync 4 high, 3 low, gate 11 high, period 31. Expect at the 2nd sync rise valid=1 with meas_sync=3, meas_gdel=2, meas_gate=10, meas_len=30. Expect locked=1 at the valid following LOCK_LINES matching comparisons (3rd valid for LOCK_LINES=2).
- Same stream with ena toggling 1/0: identical meas_* values; valid pulses last exactly one clk.
- Once locked, change the period to 41: the first valid has meas_len=40 and locked=0; locked reasserts after 2 more matching periods.
- Gate rises while sync is high: err pulse, locked=0, meas_* unchanged, state returns to IDLE.
- Sync high for 300 cycles: ovf set. At the next sync rise, err=1, valid=0, meas_* hold.
- Assert rst_n=0 in the middle of GATE: all outputs 0 immediately. After release, no valid until the 2nd sync rise.

Source files
------------

// File: rtl/video_tim_meas.sv
// Measures sync width, gate delay, gate width and period of one video timing axis.
// Latency: meas_*/valid/err update on the clk edge that samples the closing sync rise.
// Backpressure: none; ena=0 freezes all state and forces valid/err low.
module video_tim_meas #(
    parameter int LOCK_LINES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        sync,
    input  logic        gate,
    output logic [7:0]  meas_sync,
    output logic [7:0]  meas_gdel,
    output logic [15:0] meas_gate,
    output logic [15:0] meas_len,
    output logic        valid,
    output logic        locked,
    output logic        err
);

    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_SYNC = 5'b00010;
    localparam logic [4:0] S_GDEL = 5'b00100;
    localparam logic [4:0] S_GATE = 5'b01000;
    localparam logic [4:0] S_LEN  = 5'b10000;

    localparam logic [3:0] LOCK_THR = LOCK_LINES[3:0];

    logic [4:0]  r_state;
    logic [4:0]  w_nxt;
    logic        r_sync_d;
    logic        r_gate_d;
    logic [15:0] r_seg_cnt;
    logic [15:0] r_len_cnt;
    logic        r_ovf;
    logic [7:0]  r_cap_sync;
    logic [7:0]  r_cap_gdel;
    logic [15:0] r_cap_gate;
    logic [7:0]  r_meas_sync;
    logic [7:0]  r_meas_gdel;
    logic [15:0] r_meas_gate;
    logic [15:0] r_meas_len;
    logic        r_valid;
    logic        r_err;
    logic        r_locked;
    logic [3:0]  r_match_cnt;

    logic        w_rise_sync;
    logic        w_rise_gate;
    logic        w_perr;
    logic        w_close;
    logic        w_clr_all;
    logic        w_seg_inc;
    logic        w_seg_clr;
    logic [15:0] w_seg_max;
    logic        w_cap_sync_en;
    logic        w_cap_gdel_en;
    logic        w_cap_gate_en;
    logic        w_len_inc;
    logic        w_ovf_set;
    logic        w_vld;
    logic        w_errp;
    logic [15:0] w_gate_val;
    logic        w_match;
    logic [3:0]  w_match_nxt;

    assign w_rise_sync = sync & ~r_sync_d;
    assign w_rise_gate = gate & ~r_gate_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt   = r_state;
        w_perr  = 1'b0;
        w_close = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise_sync) w_nxt = S_SYNC;
            end
            S_SYNC: begin
                if (gate)       w_perr = 1'b1;
                else if (!sync) w_nxt  = S_GDEL;
            end
            S_GDEL: begin
                if (sync)             w_perr = 1'b1;
                else if (w_rise_gate) w_nxt  = S_GATE;
            end
            S_GATE: begin
                // gate fall coinciding with the next sync rise is a legal, zero-length LEN
                if (!gate && r_gate_d && w_rise_sync) begin
                    w_close = 1'b1;
                    w_nxt   = S_SYNC;
                end else if (sync) begin
                    w_perr = 1'b1;
                end else if (!gate) begin
                    w_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (w_rise_sync) begin
                    w_close = 1'b1;
                    w_nxt   = S_SYNC;
                end
            end
            default: w_nxt = S_IDLE;
        endcase
        if (w_perr) w_nxt = w_rise_sync ? S_SYNC : S_IDLE;
    end

    always_comb begin
        w_seg_inc     = 1'b0;
        w_seg_max     = 16'hFFFF;
        w_cap_sync_en = 1'b0;
        w_cap_gdel_en = 1'b0;
        w_cap_gate_en = 1'b0;
        w_gate_val    = r_cap_gate;
        case (r_state)
            S_SYNC: begin
                w_seg_max = 16'd255;
                if (!gate) begin
                    if (sync) w_seg_inc     = 1'b1;
                    else      w_cap_sync_en = 1'b1;
                end
            end
            S_GDEL: begin
                w_seg_max = 16'd255;
                if (!sync) begin
                    if (w_rise_gate) w_cap_gdel_en = 1'b1;
                    else if (!gate)  w_seg_inc     = 1'b1;
                end
            end
            S_GATE: begin
                w_gate_val = r_seg_cnt;
                if (gate) begin
                    if (!sync) w_seg_inc = 1'b1;
                end else if (w_close || !sync) begin
                    w_cap_gate_en = 1'b1;
                end
            end
            default: ;
        endcase
        w_clr_all = (r_state == S_IDLE) | w_close | w_perr;
        w_seg_clr = w_cap_sync_en | w_cap_gdel_en;
        w_len_inc = (r_state != S_IDLE) & ~w_clr_all;
        w_ovf_set = (w_seg_inc & (r_seg_cnt == w_seg_max)) |
                    (w_len_inc & (r_len_cnt == 16'hFFFF));
        w_vld     = w_close & ~r_ovf;
        w_errp    = w_perr | (w_close & r_ovf);
    end

    assign w_match = (r_cap_sync == r_meas_sync) && (r_cap_gdel == r_meas_gdel) &&
                     (w_gate_val == r_meas_gate) && (r_len_cnt == r_meas_len);

    always_comb begin
        if (!w_match)                  w_match_nxt = 4'd0;
        else if (r_match_cnt == 4'd15) w_match_nxt = 4'd15;
        else                           w_match_nxt = r_match_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_d    <= 1'b0;
            r_gate_d    <= 1'b0;
            r_seg_cnt   <= 16'd0;
            r_len_cnt   <= 16'd0;
            r_ovf       <= 1'b0;
            r_cap_sync  <= 8'd0;
            r_cap_gdel  <= 8'd0;
            r_cap_gate  <= 16'd0;
            r_meas_sync <= 8'd0;
            r_meas_gdel <= 8'd0;
            r_meas_gate <= 16'd0;
            r_meas_len  <= 16'd0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_locked    <= 1'b0;
            r_match_cnt <= 4'd0;
        end else if (ena) begin
            r_sync_d <= sync;
            r_gate_d <= gate;
            if (w_clr_all) begin
                r_seg_cnt <= 16'd0;
                r_len_cnt <= 16'd0;
                r_ovf     <= 1'b0;
            end else begin
                if (w_seg_clr)
                    r_seg_cnt <= 16'd0;
                else if (w_seg_inc && (r_seg_cnt != w_seg_max))
                    r_seg_cnt <= r_seg_cnt + 16'd1;
                if (w_len_inc && (r_len_cnt != 16'hFFFF))
                    r_len_cnt <= r_len_cnt + 16'd1;
                if (w_ovf_set)
                    r_ovf <= 1'b1;
            end
            if (w_cap_sync_en) r_cap_sync <= r_seg_cnt[7:0];
            if (w_cap_gdel_en) r_cap_gdel <= r_seg_cnt[7:0];
            if (w_cap_gate_en) r_cap_gate <= r_seg_cnt;
            r_valid <= w_vld;
            r_err   <= w_errp;
            if (w_vld) begin
                r_meas_sync <= r_cap_sync;
                r_meas_gdel <= r_cap_gdel;
                r_meas_gate <= w_gate_val;
                r_meas_len  <= r_len_cnt;
                r_match_cnt <= w_match_nxt;
                r_locked    <= (w_match_nxt >= LOCK_THR);
            end
            if (w_errp) begin
                r_match_cnt <= 4'd0;
                r_locked    <= 1'b0;
            end
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end
    end

    assign meas_sync = r_meas_sync;
    assign meas_gdel = r_meas_gdel;
    assign meas_gate = r_meas_gate;
    assign meas_len  = r_meas_len;
    assign valid     = r_valid;
    assign locked    = r_locked;
    assign err       = r_err;

endmodule

// File: tb/tb_video_tim_meas.sv
// Directed bench for video_tim_meas: shaped sync/gate periods with hand-computed measurements.
module tb_video_tim_meas;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        sync;
    logic        gate;
    logic [7:0]  meas_sync;
    logic [7:0]  meas_gdel;
    logic [15:0] meas_gate;
    logic [15:0] meas_len;
    logic        valid;
    logic        locked;
    logic        err;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_both = 0;
    int   n_bad = 0;
    int   vtot;
    int   etot;
    logic v0;
    logic e0;

    video_tim_meas #(.LOCK_LINES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .sync      (sync),
        .gate      (gate),
        .meas_sync (meas_sync),
        .meas_gdel (meas_gdel),
        .meas_gate (meas_gate),
        .meas_len  (meas_len),
        .valid     (valid),
        .locked    (locked),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic g, input logic e);
        @(negedge clk);
        sync = s;
        gate = g;
        ena  = e;
        @(posedge clk);
        #1;
        if (valid && err) n_both++;
        if (!e && (valid || err)) n_bad++;
    endtask

    // One period: sync high for sw samples, gate high from sample gs for gw samples.
    task automatic do_period(input int sw, input int gs, input int gw, input int len,
                             input bit tog, input int nsamp);
        logic s;
        logic g;
        vtot = 0;
        etot = 0;
        for (int k = 0; k < nsamp && k < len; k++) begin
            s = (k < sw);
            g = (k >= gs) && (k < gs + gw);
            step(s, g, 1'b1);
            if (k == 0) begin
                v0 = valid;
                e0 = err;
            end
            vtot += int'(valid);
            etot += int'(err);
            if (tog) step(s, g, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b0;
        sync  = 1'b0;
        gate  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_meas_sync", 32'(meas_sync), 0);
        check_eq("rst_meas_gdel", 32'(meas_gdel), 0);
        check_eq("rst_meas_gate", 32'(meas_gate), 0);
        check_eq("rst_meas_len",  32'(meas_len), 0);
        check_eq("rst_valid",     32'(valid), 0);
        check_eq("rst_locked",    32'(locked), 0);
        check_eq("rst_err",       32'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);

        do_period(4, 7, 11, 31, 0, 31);
        check_eq("first_rise_no_vld", 32'(v0), 0);
        check_eq("first_period_vtot", 32'(vtot), 0);
        do_period(4, 7, 11, 31, 0, 31);
        check_eq("p2_vld",  32'(v0), 1);
        check_eq("p2_vtot", 32'(vtot), 1);
        check_eq("p2_sync", 32'(meas_sync), 3);
        check_eq("p2_gdel", 32'(meas_gdel), 2);
        check_eq("p2_gate", 32'(meas_gate), 10);
        check_eq("p2_len",  32'(meas_len), 30);
        check_eq("p2_lock", 32'(locked), 0);
        do_period(4, 7, 11, 31, 0, 31);
        check_eq("p3_vld",  32'(v0), 1);
        check_eq("p3_lock", 32'(locked), 0);
        do_period(4, 7, 11, 31, 0, 31);
        check_eq("p4_vld",  32'(v0), 1);
        check_eq("p4_lock", 32'(locked), 1);

        do_period(4, 7, 11, 31, 1, 31);
        check_eq("tog1_vld", 32'(v0), 1);
        do_period(4, 7, 11, 31, 1, 31);
        check_eq("tog2_vld",  32'(v0), 1);
        check_eq("tog2_sync", 32'(meas_sync), 3);
        check_eq("tog2_gdel", 32'(meas_gdel), 2);
        check_eq("tog2_gate", 32'(meas_gate), 10);
        check_eq("tog2_len",  32'(meas_len), 30);
        check_eq("tog2_lock", 32'(locked), 1);

        do_period(4, 7, 11, 41, 0, 41);
        check_eq("l41a_len",  32'(meas_len), 30);
        check_eq("l41a_lock", 32'(locked), 1);
        do_period(4, 7, 11, 41, 0, 41);
        check_eq("l41b_vld",  32'(v0), 1);
        check_eq("l41b_len",  32'(meas_len), 40);
        check_eq("l41b_lock", 32'(locked), 0);
        do_period(4, 7, 11, 41, 0, 41);
        check_eq("l41c_lock", 32'(locked), 0);
        do_period(4, 7, 11, 41, 0, 41);
        check_eq("l41d_lock", 32'(locked), 1);

        do_period(4, 2, 11, 31, 0, 31);
        check_eq("perr_start_vld", 32'(v0), 1);
        check_eq("perr_etot",      32'(etot), 1);
        check_eq("perr_lock",      32'(locked), 0);
        check_eq("perr_len_hold",  32'(meas_len), 40);
        check_eq("perr_gate_hold", 32'(meas_gate), 10);
        do_period(4, 7, 11, 31, 0, 31);
        check_eq("perr_idle_no_vld", 32'(v0), 0);
        check_eq("perr_idle_no_err", 32'(e0), 0);
        do_period(4, 7, 11, 31, 0, 31);
        check_eq("perr_recover_vld",  32'(v0), 1);
        check_eq("perr_recover_len",  32'(meas_len), 30);
        check_eq("perr_recover_lock", 32'(locked), 0);

        do_period(300, 303, 11, 330, 0, 330);
        check_eq("ovf_prev_vld", 32'(v0), 1);
        do_period(4, 7, 11, 31, 0, 31);
        check_eq("ovf_err",       32'(e0), 1);
        check_eq("ovf_no_vld",    32'(v0), 0);
        check_eq("ovf_sync_hold", 32'(meas_sync), 3);
        check_eq("ovf_len_hold",  32'(meas_len), 30);
        check_eq("ovf_lock",      32'(locked), 0);
        do_period(4, 7, 11, 31, 0, 31);
        check_eq("ovf_next_vld",  32'(v0), 1);
        check_eq("ovf_next_lock", 32'(locked), 0);
        do_period(4, 7, 11, 31, 0, 31);
        check_eq("relock", 32'(locked), 1);

        do_period(4, 7, 11, 31, 0, 11);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_meas_sync", 32'(meas_sync), 0);
        check_eq("arst_meas_gdel", 32'(meas_gdel), 0);
        check_eq("arst_meas_gate", 32'(meas_gate), 0);
        check_eq("arst_meas_len",  32'(meas_len), 0);
        check_eq("arst_locked",    32'(locked), 0);
        check_eq("arst_valid",     32'(valid), 0);
        check_eq("arst_err",       32'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_period(4, 7, 11, 31, 0, 31);
        check_eq("post_rst_no_vld", 32'(vtot), 0);
        do_period(4, 7, 24, 31, 0, 31);
        check_eq("post_rst_vld", 32'(v0), 1);
        check_eq("post_rst_len", 32'(meas_len), 30);
        do_period(4, 7, 11, 31, 0, 1);
        check_eq("simul_vld",  32'(v0), 1);
        check_eq("simul_err",  32'(e0), 0);
        check_eq("simul_gate", 32'(meas_gate), 23);
        check_eq("simul_len",  32'(meas_len), 30);

        check_eq("vld_err_both", 32'(n_both), 0);
        check_eq("pulse_on_ena0", 32'(n_bad), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
